// File: rtl/arith_pkg.sv
// arith_pkg: shared arithmetic types, widths and helpers
package arith_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam int DIV_W = 8;
  function automatic logic [63:0] negate_n(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction
endpackage

// File: rtl/divider_seq_if.sv
// divider_seq_if: start/done handshake and operand/result bundle for the divider
interface divider_seq_if import arith_pkg::*; #(parameter int N = DIV_W);
  logic start;
  logic signed_mode;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic busy;
  logic done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic div_by_zero;
  modport master(output start, signed_mode, dividend, divisor, input busy, done, quotient, remainder, div_by_zero);
  modport slave(input start, signed_mode, dividend, divisor, output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/div_step.sv
// div_step: one restoring-division step, N+1-bit trial subtract via ripple adder
module div_step import arith_pkg::*; #(parameter int N = DIV_W) (
  input  logic [N:0] rem,
  input  logic [N:0] dsr,
  output logic [N:0] rem_next,
  output logic       q_bit
);
  logic [N:0] b, s;
  logic [N+1:0] c;
  // rem + ~dsr + 1; carry out set means the difference is non-negative
  always_comb begin
    b = ~dsr;
    s = '0;
    c = '0;
    c[0] = 1'b1;
    for (int i = 0; i <= N; i++) begin
      s[i] = rem[i] ^ b[i] ^ c[i];
      c[i+1] = (rem[i] & b[i]) | (c[i] & (rem[i] ^ b[i]));
    end
    q_bit = c[N+1];
    rem_next = q_bit ? s : rem;
  end
endmodule

// File: rtl/divider_seq.sv
// divider_seq: iterative radix-2 restoring divider, signed/unsigned, one quotient bit per clock
module divider_seq import arith_pkg::*; #(parameter int N = DIV_W) (
  input logic clk,
  input logic rst,
  divider_seq_if.slave bus
);
  localparam int CW = $clog2(N);
  state_t state, state_n;
  logic [N:0] rem, rem_sh, rem_nx;
  logic [N-1:0] dvd, dsr, mag_a, mag_b, q_fix, r_fix;
  logic [CW-1:0] cnt;
  logic q_neg, r_neg, dz, q_bit, sa, sb;
  assign rem_sh = (rem << 1) | (N+1)'(dvd[N-1]);
  assign bus.busy = state != IDLE;
  div_step #(.N(N)) u_step (.rem(rem_sh), .dsr({1'b0, dsr}), .rem_next(rem_nx), .q_bit(q_bit));
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state, operand magnitudes and sign fix-up
  always_comb begin
    state_n = (state == IDLE) ? (bus.start ? CALC : IDLE) :
              (state == CALC) ? ((cnt == '0) ? FIX : CALC) :
              (state == FIX) ? DONE : IDLE;
    sa = bus.signed_mode & bus.dividend[N-1];
    sb = bus.signed_mode & bus.divisor[N-1];
    mag_a = sa ? N'(negate_n(64'(bus.dividend))) : bus.dividend;
    mag_b = sb ? N'(negate_n(64'(bus.divisor))) : bus.divisor;
    q_fix = dz ? '1 : q_neg ? N'(negate_n(64'(dvd))) : dvd;
    r_fix = r_neg ? N'(negate_n(64'(N'(rem)))) : N'(rem);
  end
  // capture, iterate, fix signs, then publish results with a done pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rem <= '0;
      dvd <= '0;
      dsr <= '0;
      cnt <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dz <= 1'b0;
      bus.done <= 1'b0;
      bus.quotient <= '0;
      bus.remainder <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        rem <= '0;
        dvd <= mag_a;
        dsr <= mag_b;
        cnt <= CW'(N - 1);
        q_neg <= sa ^ sb;
        r_neg <= sa;
        dz <= bus.divisor == '0;
      end else if (state == CALC) begin
        rem <= rem_nx;
        dvd <= {dvd[N-2:0], q_bit};
        cnt <= cnt - CW'(1);
      end else if (state == FIX) begin
        dvd <= q_fix;
        rem <= {1'b0, r_fix};
      end
      bus.done <= state == DONE;
      if (state == DONE) begin
        bus.quotient <= dvd;
        bus.remainder <= N'(rem);
        bus.div_by_zero <= dz;
      end
    end
endmodule
